// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU microcode sequencer: state encoding,
// default program length and the ROM field widths.
package alu_sequencer_pkg;

    // Default program length; the last ROM word is PROG_SIZE_DEFAULT-1.
    localparam int PROG_SIZE_DEFAULT = 100;
    localparam int PROG_ADDR_BITS    = 7;

    // ROM field widths shared with the ALU program ROM.
    localparam int A_SRC_BITS       = 3;
    localparam int S_SRC_BITS       = 3;
    localparam int SHIFT_COUNT_BITS = 4;
    localparam int MOP_FLAG_BITS    = 4;
    localparam int NUM_ALU_REGS     = 8;
    localparam int FASRC_BITS       = 3;
    localparam int TAG_BITS         = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // One microinstruction as it travels from the ROM into the execute stage.
    typedef struct packed {
        logic [A_SRC_BITS-1:0]       a_src;
        logic [S_SRC_BITS-1:0]       s_src;
        logic [SHIFT_COUNT_BITS-1:0] shift;
        logic [MOP_FLAG_BITS-1:0]    flags;
        logic [NUM_ALU_REGS-1:0]     dmask;
        logic [FASRC_BITS-1:0]       fasrc;
        logic [TAG_BITS-1:0]         tag;
    } ex_fields_t;

endpackage

// File: rtl/alu_ex_reg.sv
// Execute-stage register bank: loads an issued ROM word, holds it while
// stalled, and turns into an all-zero NOP whenever nothing is issued.
module alu_ex_reg
    import alu_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       hold_i,
    input  logic       issue_i,
    input  logic       last_i,
    input  ex_fields_t fields_i,
    output ex_fields_t fields_o,
    output logic       valid_o,
    output logic       last_o
);

    ex_fields_t fields_q, fields_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;

    // Next-state: flush beats hold, hold beats load, otherwise insert a NOP.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can leave one unassigned and infer a latch.
        fields_d = fields_q;
        valid_d  = valid_q;
        last_d   = last_q;
        if (flush_i) begin
            fields_d = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
        end else if (!hold_i) begin
            if (issue_i) begin
                fields_d = fields_i;
                valid_d  = 1'b1;
                last_d   = last_i;
            end else begin
                // Zero flags and dmask mean the datapath writes no register.
                fields_d = '0;
                valid_d  = 1'b0;
                last_d   = 1'b0;
            end
        end
    end

    // Execute-stage registers with asynchronous reset to a NOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fields_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so all registers sample pre-edge values together.
            fields_q <= fields_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign fields_o = fields_q;
    assign valid_o  = valid_q;
    assign last_o   = last_q;

endmodule

// File: rtl/alu_sequencer.sv
// Microcode sequencer: walks ROM addresses 0..PROG_SIZE-1 once per start
// request, queues one further run, supports stall and abort, and feeds the
// execute stage.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int PROG_SIZE = PROG_SIZE_DEFAULT,
    parameter int AW        = PROG_ADDR_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stall,
    input  logic                        abort,
    output logic [AW-1:0]               addr,
    input  logic [A_SRC_BITS-1:0]       rom_a_src,
    input  logic [S_SRC_BITS-1:0]       rom_s_src,
    input  logic [SHIFT_COUNT_BITS-1:0] rom_shift,
    input  logic [MOP_FLAG_BITS-1:0]    rom_flags,
    input  logic [NUM_ALU_REGS-1:0]     rom_dmask,
    input  logic [FASRC_BITS-1:0]       rom_fasrc,
    input  logic [TAG_BITS-1:0]         rom_tag,
    output logic [A_SRC_BITS-1:0]       ex_a_src,
    output logic [S_SRC_BITS-1:0]       ex_s_src,
    output logic [SHIFT_COUNT_BITS-1:0] ex_shift,
    output logic [MOP_FLAG_BITS-1:0]    ex_flags,
    output logic [NUM_ALU_REGS-1:0]     ex_dmask,
    output logic [FASRC_BITS-1:0]       ex_fasrc,
    output logic [TAG_BITS-1:0]         ex_tag,
    output logic                        ex_valid,
    output logic                        ex_fire,
    output logic                        ex_last,
    output logic                        done,
    output logic                        busy
);

    localparam logic [AW-1:0] LAST_PC = AW'(PROG_SIZE - 1);

    seq_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          pending_q, pending_d;
    logic          go;
    logic          issue;
    ex_fields_t    rom_fields;
    ex_fields_t    ex_fields;

    // A run may begin from a latched request or from start in this very cycle.
    assign go    = pending_q | start;
    assign issue = (state_q == RUN);

    // Sequencer next-state: abort wins, stall freezes, the last word either
    // wraps into a queued run or returns to IDLE.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q | start;
        if (abort) begin
            state_d   = IDLE;
            pc_d      = '0;
            pending_d = 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        state_d   = RUN;
                        pc_d      = '0;
                        pending_d = 1'b0;
                    end
                end
                RUN: begin
                    if (pc_q == LAST_PC) begin
                        pc_d      = '0;
                        pending_d = 1'b0;
                        if (!go) begin
                            state_d = IDLE;
                        end
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, program counter and pending-request register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
    end

    assign rom_fields.a_src = rom_a_src;
    assign rom_fields.s_src = rom_s_src;
    assign rom_fields.shift = rom_shift;
    assign rom_fields.flags = rom_flags;
    assign rom_fields.dmask = rom_dmask;
    assign rom_fields.fasrc = rom_fasrc;
    assign rom_fields.tag   = rom_tag;

    alu_ex_reg u_ex_reg (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (abort),
        .hold_i   (stall),
        .issue_i  (issue),
        .last_i   (pc_q == LAST_PC),
        .fields_i (rom_fields),
        .fields_o (ex_fields),
        .valid_o  (ex_valid),
        .last_o   (ex_last)
    );

    assign addr     = pc_q;
    assign ex_a_src = ex_fields.a_src;
    assign ex_s_src = ex_fields.s_src;
    assign ex_shift = ex_fields.shift;
    assign ex_flags = ex_fields.flags;
    assign ex_dmask = ex_fields.dmask;
    assign ex_fasrc = ex_fields.fasrc;
    assign ex_tag   = ex_fields.tag;
    assign ex_fire  = ex_valid & ~stall;
    assign done     = ex_fire & ex_last;
    assign busy     = (state_q == RUN) | ex_valid;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a stub ROM and a behavioural
// model of the run/pending/execute rules.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int PS = 100;
    localparam int AW = PROG_ADDR_BITS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic abort = 1'b0;

    logic [AW-1:0]               addr;
    logic [A_SRC_BITS-1:0]       rom_a_src, ex_a_src;
    logic [S_SRC_BITS-1:0]       rom_s_src, ex_s_src;
    logic [SHIFT_COUNT_BITS-1:0] rom_shift, ex_shift;
    logic [MOP_FLAG_BITS-1:0]    rom_flags, ex_flags;
    logic [NUM_ALU_REGS-1:0]     rom_dmask, ex_dmask;
    logic [FASRC_BITS-1:0]       rom_fasrc, ex_fasrc;
    logic [TAG_BITS-1:0]         rom_tag, ex_tag;
    logic ex_valid, ex_fire, ex_last, done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Stub program ROM: every word is derived from its own address.
    assign rom_a_src = A_SRC_BITS'(addr);
    assign rom_s_src = S_SRC_BITS'(addr);
    assign rom_shift = SHIFT_COUNT_BITS'(addr);
    assign rom_flags = MOP_FLAG_BITS'(1);
    assign rom_dmask = NUM_ALU_REGS'(addr);
    assign rom_fasrc = FASRC_BITS'(addr);
    assign rom_tag   = addr[2:0];

    alu_sequencer #(.PROG_SIZE(PS), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .abort(abort),
        .addr(addr),
        .rom_a_src(rom_a_src), .rom_s_src(rom_s_src), .rom_shift(rom_shift),
        .rom_flags(rom_flags), .rom_dmask(rom_dmask), .rom_fasrc(rom_fasrc),
        .rom_tag(rom_tag),
        .ex_a_src(ex_a_src), .ex_s_src(ex_s_src), .ex_shift(ex_shift),
        .ex_flags(ex_flags), .ex_dmask(ex_dmask), .ex_fasrc(ex_fasrc),
        .ex_tag(ex_tag),
        .ex_valid(ex_valid), .ex_fire(ex_fire), .ex_last(ex_last),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which program word is running, whether a further run
    // is requested, and which word (if any) sits in the execute stage.
    bit m_run, m_pend, m_v, m_last;
    int m_pc, m_word;

    always @(posedge clk or posedge reset) begin : model
        bit want;
        if (reset || abort) begin
            m_run = 0; m_pend = 0; m_v = 0; m_last = 0; m_pc = 0; m_word = 0;
        end else if (stall) begin
            m_pend = m_pend | start;
        end else begin
            want = m_pend | start;
            if (m_run) begin
                m_v    = 1;
                m_word = m_pc;
                m_last = (m_pc == PS - 1);
                if (m_pc == PS - 1) begin
                    m_pc   = 0;
                    m_run  = want;
                    m_pend = 0;
                end else begin
                    m_pc   = m_pc + 1;
                    m_pend = want;
                end
            end else begin
                m_v = 0; m_word = 0; m_last = 0;
                if (want) begin
                    m_run = 1; m_pc = 0; m_pend = 0;
                end
            end
        end
    end

    // Compare every cycle, between edges, against the model.
    always @(negedge clk) begin
        check("addr",     32'(addr),     32'(m_pc));
        check("ex_valid", 32'(ex_valid), 32'(m_v));
        check("ex_last",  32'(ex_last),  32'(m_v & m_last));
        check("ex_fire",  32'(ex_fire),  32'(m_v & !stall));
        check("done",     32'(done),     32'(m_v & !stall & m_last));
        check("busy",     32'(busy),     32'(m_run | m_v));
        check("ex_dmask", 32'(ex_dmask), m_v ? 32'(m_word % (1 << NUM_ALU_REGS)) : 32'd0);
        check("ex_flags", 32'(ex_flags), m_v ? 32'd1 : 32'd0);
        if (m_v) begin
            check("ex_a_src", 32'(ex_a_src), 32'(m_word % (1 << A_SRC_BITS)));
            check("ex_s_src", 32'(ex_s_src), 32'(m_word % (1 << S_SRC_BITS)));
            check("ex_shift", 32'(ex_shift), 32'(m_word % (1 << SHIFT_COUNT_BITS)));
            check("ex_fasrc", 32'(ex_fasrc), 32'(m_word % (1 << FASRC_BITS)));
            check("ex_tag",   32'(ex_tag),   32'(m_word % 8));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Launch one run with a start pulse (or held start) and track its
    // sequence, done timing and optional stall/restart stimulus.
    task automatic run_seq(input int stall_word, input int stall_len, input int restart_pc,
                           input int hold_cycles, input int exp_first, input int exp_second,
                           input int exp_dones, input string tag);
        int n = 0, k = 0, dones = 0, first_done = -1, second_done = -1, stalls_left = 0;
        bit stalled_once = 0, restarted = 0, bubble_chk = 0;
        start = 1'b1;
        step();
        while (n < 1000) begin
            if (hold_cycles > 0) begin
                start = (n < hold_cycles);
            end else if (restart_pc >= 0 && !restarted && int'(addr) == restart_pc) begin
                start = 1'b1;
                restarted = 1;
            end else begin
                start = 1'b0;
            end
            if (stall_len > 0 && !stalled_once && ex_valid && int'(ex_dmask) == stall_word) begin
                stalls_left  = stall_len;
                stalled_once = 1;
            end
            stall = (stalls_left > 0);
            if (stalls_left > 0) stalls_left--;
            @(negedge clk);
            if (stall) begin
                check({tag, "_stall_fire"}, 32'(ex_fire), 32'd0);
                check({tag, "_stall_hold"}, 32'(ex_dmask), 32'(stall_word));
            end
            if (bubble_chk) begin
                check({tag, "_nobubble_valid"}, 32'(ex_valid), 32'd1);
                check({tag, "_nobubble_word"},  32'(ex_dmask), 32'd0);
                bubble_chk = 0;
            end
            if (hold_cycles > 0 && n >= 1 && n <= hold_cycles)
                check({tag, "_valid_gapless"}, 32'(ex_valid), 32'd1);
            if (ex_fire) begin
                check({tag, "_seq"}, 32'(ex_dmask), 32'(k % PS));
                k++;
            end
            if (done) begin
                dones++;
                if (first_done < 0) first_done = n;
                else if (second_done < 0) second_done = n;
                if (dones < exp_dones) bubble_chk = 1;
            end
            if (!busy && n > 0 && !start) break;
            step();
            n++;
        end
        stall = 1'b0;
        start = 1'b0;
        check({tag, "_first_done_cycle"},  32'(first_done),  32'(exp_first));
        check({tag, "_second_done_cycle"}, 32'(second_done), 32'(exp_second));
        check({tag, "_done_count"},        32'(dones),       32'(exp_dones));
        check({tag, "_fire_count"},        32'(k),           32'(exp_dones * PS));
        check({tag, "_end_valid"},         32'(ex_valid),    32'd0);
        check({tag, "_end_busy"},          32'(busy),        32'd0);
        step();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit found;
        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr",  32'(addr),     32'd0);
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_dmask", 32'(ex_dmask), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Plain run, stalled run, back-to-back via second start.
        run_seq(-1, 0, -1, 0, 100, -1, 1, "run");
        run_seq(10, 3, -1, 0, 103, -1, 1, "stall");
        run_seq(-1, 0, 50, 0, 100, 200, 2, "b2b");

        // Abort at word 40 with a coincident start.
        start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (ex_valid && ex_dmask == NUM_ALU_REGS'(40)) begin found = 1; break; end
            step();
        end
        check("abort_reached_40", 32'(found), 32'd1);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(ex_valid), 32'd0);
        check("abort_dmask", 32'(ex_dmask), 32'd0);
        check("abort_flags", 32'(ex_flags), 32'd0);
        check("abort_addr",  32'(addr),     32'd0);
        check("abort_busy",  32'(busy),     32'd0);
        repeat (5) step();
        check("abort_start_dropped", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a run at pc=70.
        start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (addr == AW'(70)) begin found = 1; break; end
            step();
        end
        check("reset_reached_70", 32'(found), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_addr",  32'(addr),     32'd0);
        check("arst_valid", 32'(ex_valid), 32'd0);
        check("arst_busy",  32'(busy),     32'd0);
        check("arst_done",  32'(done),     32'd0);
        check("arst_dmask", 32'(ex_dmask), 32'd0);
        check("arst_flags", 32'(ex_flags), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        run_seq(-1, 0, -1, 0, 100, -1, 1, "post_rst");

        // Start held for 250 cycles: four back-to-back runs.
        run_seq(-1, 0, -1, 250, 100, 200, 4, "held");

        // Randomized stimulus checked by the model.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 99) < 8);
            stall = ($urandom_range(0, 99) < 20);
            abort = ($urandom_range(0, 99) < 2);
            reset = ($urandom_range(0, 999) < 3);
            step();
        end
        start = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Microcode sequencer in front of the ALU program ROM. Generates the ROM address, walks the fixed program from 0 to PROG_SIZE-1 once per start request, and registers the ROM fields into an execute stage for the ALU datapath. Also provides stall and abort handling, back-to-back runs without a bubble, and a done pulse.

## Interface

Parameters:
- PROG_SIZE, 100: number of program words; the last address is PROG_SIZE-1.
- AW, `PROG_ADDR_BITS: address width; AW must satisfy 2^AW >= PROG_SIZE.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  run request, one-cycle pulse or held level.
- stall  in  1  freezes the sequencer and the execute stage.
- abort  in  1  synchronous; kills the current run.
- addr  out  AW  ROM address; registered, equals pc.
- rom_a_src, rom_s_src, rom_shift, rom_flags, rom_dmask, rom_fasrc, rom_tag  in  `A_SRC_BITS / `S_SRC_BITS / `SHIFT_COUNT_BITS / `MOP_FLAG_BITS / `NUM_ALU_REGS / 3 / `TAG_BITS  ROM fields for addr (combinational ROM).
- ex_a_src, ex_s_src, ex_shift, ex_flags, ex_dmask, ex_fasrc, ex_tag  out  same widths  registered execute-stage fields.
- ex_valid  out  1  execute stage holds a live instruction.
- ex_fire  out  1  ex_valid & ~stall; the datapath consumes on this signal only.
- ex_last  out  1  execute instruction is word PROG_SIZE-1.
- done  out  1  equals ex_fire & ex_last.
- busy  out  1  state is RUN, or ex_valid is set.

## Operation

- States: IDLE, RUN. A pending flag latches start.
- Pending flag:
  - Set by start in any cycle.
  - Cleared when a run begins or on abort.
  - Run begins in IDLE when pending|start is true and stall=0. State goes to RUN with pc=0.
- RUN with stall=0, each cycle:
  - Execute registers load the rom_* fields; ex_valid=1.
  - ex_last = (pc==PROG_SIZE-1).
  - pc increments.
- Issuing pc=PROG_SIZE-1:
  - If pending|start is true, pc=0 and the state stays RUN (back-to-back, no bubble).
  - Otherwise pc=0, state goes to IDLE, and ex_valid drops after the final instruction is consumed.
- stall=1: pc, state, ex_* and ex_valid hold; pending may still be set.
- IDLE with stall=0: ex_valid is cleared the cycle after the last instruction fires. While ex_valid=0, ex_flags and ex_dmask are forced to 0 (NOP: no register writes).
- abort (highest priority over start and stall):
  - Next edge: state=IDLE, pc=0, ex_valid=0, ex_* NOP, pending=0.
  - A start in the same cycle as abort is dropped.
- start during RUN queues exactly one further run. Multiple starts do not accumulate.
- addr==pc; pc never exceeds PROG_SIZE-1.

## Timing

- Reset values: state IDLE, pc=0, addr=0, pending=0, ex_valid=0, all ex_* fields 0, ex_fire/ex_last/done/busy 0.
- start sampled at edge E0 (stall=0):
  - addr=0 after E0.
  - Instruction 0 appears on ex_* after E1.
  - Instruction k appears after E(k+1).
  - done is high in the cycle after E(PROG_SIZE) with no stalls: 100 cycles from the start edge.
- Each stall cycle adds exactly one cycle of latency. No instruction is skipped or duplicated at ex_fire.
- Back-to-back: instruction 0 of the next run appears in the cycle after done. ex_valid stays high throughout.
- Reset asserted mid-run returns immediately to the reset values; ex_valid drops without an edge.

## Structure

- Shared package/defines file holds: the state encoding (IDLE=0, RUN=1), PROG_SIZE, and the field-width macros already used by the ALU program ROM.
- One natural sub-module: alu_ex_reg, the execute-stage register bank with hold-on-stall and NOP-forcing. The sequencer FSM and pc stay in alu_sequencer.

## Test plan

Bench uses a stub ROM driving rom_dmask=addr, rom_tag=addr[2:0], rom_flags=1, and other fields=addr.

- start pulse, no stall -> ex_dmask steps 0,1,…,99 on consecutive cycles. done is high exactly once, 100 cycles after the start edge. ex_valid is low afterwards and busy=0.
- stall high for 3 cycles while ex_dmask=10 -> ex_dmask=10 is held, ex_fire=0 for those 3 cycles. Sequence resumes at 11. done arrives 3 cycles later than in the unstalled run.
- Second start pulse while pc=50 -> after ex_dmask=99 with done=1, the next cycle shows ex_dmask=0 with ex_valid=1 (no bubble). Exactly two done pulses in total.
- abort while ex_dmask=40 -> next cycle ex_valid=0, ex_dmask=0, ex_flags=0, addr=0, busy=0. A start coincident with abort causes no run.
- reset asserted asynchronously mid-cycle at pc=70 -> outputs go to reset values before the next edge. After release, start produces a full 0..99 run.
- start held high continuously for 250 cycles -> runs repeat back-to-back. done pulses at cycles 100 and 200 with no gaps in ex_valid.
